// File: rtl/cra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cra_pkg
// Description : Shared types and helpers for the chunked ripple accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package cra_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Counter width for a slice index; never narrower than one bit.
    function automatic int slice_cnt_width(input int slices);
        return (slices <= 2) ? 1 : $clog2(slices);
    endfunction

endpackage
`default_nettype wire

// File: rtl/HexDriver.sv
`default_nettype none
// ============================================================================
// Module      : HexDriver
// Description : Nibble to active-low 7-segment decoder (bit 6 = segment g).
// Revision    : 1.0 - initial release
// ============================================================================
module HexDriver (
    input  logic [3:0] In0,
    output logic [6:0] Out0
);

    always_comb begin
        Out0 = 7'h7F;
        case (In0)
            4'h0: Out0 = 7'h40;
            4'h1: Out0 = 7'h79;
            4'h2: Out0 = 7'h24;
            4'h3: Out0 = 7'h30;
            4'h4: Out0 = 7'h19;
            4'h5: Out0 = 7'h12;
            4'h6: Out0 = 7'h02;
            4'h7: Out0 = 7'h78;
            4'h8: Out0 = 7'h00;
            4'h9: Out0 = 7'h10;
            4'hA: Out0 = 7'h08;
            4'hB: Out0 = 7'h03;
            4'hC: Out0 = 7'h46;
            4'hD: Out0 = 7'h21;
            4'hE: Out0 = 7'h06;
            4'hF: Out0 = 7'h0E;
            default: Out0 = 7'h7F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cra_accum_datapath_slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : slice_adder
// Description : Combinational CHUNK-bit ripple-carry adder (a + b + cin).
// Revision    : 1.0 - initial release
// ============================================================================
module slice_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[CHUNK];

endmodule
`default_nettype wire

// File: rtl/cra_accum_datapath.sv
`default_nettype none
// ============================================================================
// Module      : cra_accum_datapath
// Description : Accumulator B +/- SW, computed one CHUNK-bit slice per cycle,
//               with hex display decoding of SW and B.
// Revision    : 1.0 - initial release
// ============================================================================
module cra_accum_datapath
    import cra_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Load_B,
    input  logic                    Run,
    input  logic                    Sub,
    input  logic [WIDTH-1:0]        SW,
    output logic                    Busy,
    output logic                    Done,
    output logic                    C_out,
    output logic                    V_out,
    output logic [WIDTH-1:0]        reg_out,
    output logic [WIDTH/4-1:0][6:0] Ahex,
    output logic [WIDTH/4-1:0][6:0] Bhex
);

    localparam int             SLICES     = WIDTH / CHUNK;
    localparam int             CW         = slice_cnt_width(SLICES);
    localparam logic [CW-1:0]  LAST_SLICE = CW'(SLICES - 1);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_COMPUTE = COMPUTE;
    localparam logic [1:0] S_DONE    = DONE;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_slice;
    logic             r_carry;
    logic             r_sub_q;
    logic [WIDTH-1:0] r_a_q;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic             r_v;

    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_sum;
    logic             w_cin;
    logic             w_cout;
    logic [WIDTH-1:0] w_result;
    logic             w_v;

    assign w_b_slice = r_b[r_slice*CHUNK +: CHUNK];
    assign w_a_slice = r_a_q[r_slice*CHUNK +: CHUNK];
    // Slice 0 takes the subtract flag directly as the two's-complement +1.
    assign w_cin     = (r_slice == '0) ? r_sub_q : r_carry;

    slice_adder #(
        .CHUNK (CHUNK)
    ) u_slice_adder (
        .i_a    (w_b_slice),
        .i_b    (w_a_slice),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_result = r_shadow;
        w_result[r_slice*CHUNK +: CHUNK] = w_sum;
    end

    assign w_v = (r_b[WIDTH-1] == r_a_q[WIDTH-1]) && (w_result[WIDTH-1] != r_b[WIDTH-1]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_slice  <= '0;
            r_carry  <= 1'b0;
            r_sub_q  <= 1'b0;
            r_a_q    <= '0;
            r_shadow <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Load_B) begin
                        r_b <= SW;
                        r_c <= 1'b0;
                        r_v <= 1'b0;
                    end else if (Run) begin
                        r_a_q    <= Sub ? ~SW : SW;
                        r_sub_q  <= Sub;
                        r_carry  <= Sub;
                        r_slice  <= '0;
                        r_shadow <= '0;
                        r_state  <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    r_shadow <= w_result;
                    r_carry  <= w_cout;
                    if (r_slice == LAST_SLICE) begin
                        r_b     <= w_result;
                        r_c     <= w_cout;
                        r_v     <= w_v;
                        r_slice <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_slice <= r_slice + 1'b1;
                    end
                end
                S_DONE: begin
                    // Wait for release so a held button yields one accumulate.
                    if (!Run) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy    = (r_state == S_COMPUTE);
    assign Done    = (r_state == S_DONE);
    assign C_out   = r_c;
    assign V_out   = r_v;
    assign reg_out = r_b;

    for (genvar i = 0; i < WIDTH/4; i++) begin : g_hex
        HexDriver u_hex_a (
            .In0  (SW[4*i +: 4]),
            .Out0 (Ahex[i])
        );
        HexDriver u_hex_b (
            .In0  (r_b[4*i +: 4]),
            .Out0 (Bhex[i])
        );
    end

endmodule
`default_nettype wire
